// File: rtl/mem_fill_check_pkg.sv
// Shared types for the memory fill/check master: command modes, FSM states
// and the test pattern generator.
package mem_fill_check_pkg;

  localparam logic [1:0] MODE_FILL       = 2'b00;
  localparam logic [1:0] MODE_CHECK      = 2'b01;
  localparam logic [1:0] MODE_FILL_CHECK = 2'b10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    CHECK = 3'd2,
    DRAIN = 3'd3,
    FIN   = 3'd4
  } state_e;

  // Pattern word for window offset `offset`; wraps modulo 2^32.
  function automatic logic [31:0] pattern_word(input logic [31:0] seed,
                                               input logic [31:0] offset);
    return seed + offset;
  endfunction

endpackage

// File: rtl/mem_fill_check_master_if.sv
// Avalon-MM bus between the fill/check master and the on-chip memory slave.
//
// Handshake: a transfer is presented whenever chipselect is high (write
// selects direction, read = chipselect & ~write) and is accepted on the
// rising edge where chipselect=1 and waitrequest=0. While waitrequest is high
// the master holds address, writedata and all qualifiers stable. Read data
// returns on readdata a fixed number of cycles after acceptance, with no
// handshake of its own.
interface mem_fill_check_master_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write;
  logic              read;
  logic [3:0]        byteenable;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic              waitrequest;

  modport master (
    output address, chipselect, write, read, byteenable, writedata,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, chipselect, write, read, byteenable, writedata,
    output readdata, waitrequest
  );
endinterface

// File: rtl/mm_rd_return_pipe.sv
// Fixed-latency return tracker: each accepted read enters as {valid, offset}
// and emerges LAT cycles later, aligned with its readdata.
module mm_rd_return_pipe #(
  parameter int LAT   = 1,
  parameter int OFF_W = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [OFF_W-1:0] push_off,
  output logic             out_valid,
  output logic [OFF_W-1:0] out_off,
  output logic             pending
);

  logic [LAT-1:0]            vld_q, vld_d;
  logic [LAT-1:0][OFF_W-1:0] off_q, off_d;

  // Shift every entry one stage toward the output; flush empties all stages.
  always_comb begin
    vld_d    = '0;
    off_d    = off_q;
    vld_d[0] = push;
    off_d[0] = push_off;
    for (int i = 1; i < LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      off_d[i] = off_q[i-1];
    end
    if (flush) vld_d = '0;
  end

  // Stage registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      off_q <= '0;
    end else begin
      vld_q <= vld_d;
      off_q <= off_d;
    end
  end

  assign out_valid = vld_q[LAT-1];
  assign out_off   = off_q[LAT-1];

  // Entries still behind the output stage; when clear the pipe is empty after
  // the current exit.
  always_comb begin
    pending = 1'b0;
    for (int i = 0; i < LAT - 1; i++) pending = pending | vld_q[i];
  end

endmodule

// File: rtl/mem_fill_check_master.sv
// Memory self-test / preload master: writes seed+i across a wrapping window,
// reads it back, counts mismatches and records the first failing address.
module mem_fill_check_master
  import mem_fill_check_pkg::*;
#(
  parameter int ADDR_W       = 11,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [1:0]           mode,
  input  logic [ADDR_W-1:0]    base,
  input  logic [ADDR_W:0]      count,
  input  logic [31:0]          seed,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_W:0]      err_count,
  output logic                 first_err_valid,
  output logic [ADDR_W-1:0]    first_err_addr,
  output state_e               dbg_state,
  mem_fill_check_master_if.master avm
);

  state_e              state_q, state_d;
  logic                check_after_q, check_after_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [31:0]         seed_q, seed_d;
  logic [ADDR_W:0]     off_q, off_d;
  logic [ADDR_W:0]     err_q, err_d;
  logic                fev_q, fev_d;
  logic [ADDR_W-1:0]   fea_q, fea_d;

  logic                pipe_push;
  logic                pipe_flush;
  logic                ret_valid;
  logic [ADDR_W-1:0]   ret_off;
  logic                ret_pending;
  logic                last_xfer;
  logic [31:0]         exp_word;

  assign last_xfer = (off_q == count_q - 1'b1);
  assign exp_word  = pattern_word(seed_q, 32'(ret_off));

  mm_rd_return_pipe #(
    .LAT   (READ_LATENCY),
    .OFF_W (ADDR_W)
  ) u_ret_pipe (
    .clk       (clk),
    .reset     (reset),
    .flush     (pipe_flush),
    .push      (pipe_push),
    .push_off  (off_q[ADDR_W-1:0]),
    .out_valid (ret_valid),
    .out_off   (ret_off),
    .pending   (ret_pending)
  );

  // Next-state, bus drive and result update for the fill/check sequencer.
  always_comb begin
    state_d       = state_q;
    check_after_d = check_after_q;
    base_d        = base_q;
    count_d       = count_q;
    seed_d        = seed_q;
    off_d         = off_q;
    err_d         = err_q;
    fev_d         = fev_q;
    fea_d         = fea_q;
    pipe_push     = 1'b0;
    pipe_flush    = (state_q == IDLE);

    avm.address    = '0;
    avm.chipselect = 1'b0;
    avm.write      = 1'b0;
    avm.read       = 1'b0;
    avm.byteenable = 4'h0;
    avm.writedata  = '0;

    // A returning read is scored the cycle its data is on readdata.
    if (ret_valid && (avm.readdata != exp_word)) begin
      err_d = err_q + 1'b1;
      if (!fev_q) begin
        fev_d = 1'b1;
        fea_d = base_q + ret_off;
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          check_after_d = mode[1];
          base_d        = base;
          count_d       = count;
          seed_d        = seed;
          off_d         = '0;
          err_d         = '0;
          fev_d         = 1'b0;
          fea_d         = '0;
          if (count == '0)             state_d = FIN;
          else if (mode == MODE_CHECK) state_d = CHECK;
          else                         state_d = FILL;
        end
      end
      FILL: begin
        avm.chipselect = 1'b1;
        avm.write      = 1'b1;
        avm.byteenable = 4'hF;
        avm.address    = base_q + off_q[ADDR_W-1:0];
        avm.writedata  = pattern_word(seed_q, 32'(off_q));
        if (!avm.waitrequest) begin
          if (last_xfer) begin
            off_d   = '0;
            state_d = check_after_q ? CHECK : FIN;
          end else begin
            off_d = off_q + 1'b1;
          end
        end
      end
      CHECK: begin
        avm.chipselect = 1'b1;
        avm.read       = 1'b1;
        avm.byteenable = 4'hF;
        avm.address    = base_q + off_q[ADDR_W-1:0];
        if (!avm.waitrequest) begin
          pipe_push = 1'b1;
          if (last_xfer) state_d = DRAIN;
          else           off_d   = off_q + 1'b1;
        end
      end
      DRAIN: begin
        if (!ret_pending) state_d = FIN;
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and result registers; reset aborts any command in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      check_after_q <= 1'b0;
      base_q        <= '0;
      count_q       <= '0;
      seed_q        <= '0;
      off_q         <= '0;
      err_q         <= '0;
      fev_q         <= 1'b0;
      fea_q         <= '0;
    end else begin
      state_q       <= state_d;
      check_after_q <= check_after_d;
      base_q        <= base_d;
      count_q       <= count_d;
      seed_q        <= seed_d;
      off_q         <= off_d;
      err_q         <= err_d;
      fev_q         <= fev_d;
      fea_q         <= fea_d;
    end
  end

  assign busy            = (state_q == FILL) || (state_q == CHECK) || (state_q == DRAIN);
  assign done            = (state_q == FIN);
  assign err_count       = err_q;
  assign first_err_valid = fev_q;
  assign first_err_addr  = fea_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_mem_fill_check_master.sv
// Directed bench for mem_fill_check_master with a behavioural 2048-word
// memory (read latency 1), optional word corruption and random stalls.
module tb_mem_fill_check_master;
  import mem_fill_check_pkg::*;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic              start = 1'b0;
  logic [1:0]        mode = 2'b00;
  logic [ADDR_W-1:0] base = '0;
  logic [ADDR_W:0]   count = '0;
  logic [31:0]       seed = '0;
  logic              busy, done, first_err_valid;
  logic [ADDR_W:0]   err_count;
  logic [ADDR_W-1:0] first_err_addr;
  state_e            dbg_state;

  int total = 0;
  int bad   = 0;

  mem_fill_check_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) avm ();

  mem_fill_check_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LATENCY(1)) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .mode            (mode),
    .base            (base),
    .count           (count),
    .seed            (seed),
    .busy            (busy),
    .done            (done),
    .err_count       (err_count),
    .first_err_valid (first_err_valid),
    .first_err_addr  (first_err_addr),
    .dbg_state       (dbg_state),
    .avm             (avm)
  );

  // ---------------- memory model ----------------
  logic [31:0]       mem [2048];
  logic [31:0]       rd_q = '0;
  logic              corrupt_en = 1'b0;
  logic [ADDR_W-1:0] corrupt_addr = '0;
  logic              rand_wait = 1'b0;
  logic [ADDR_W-1:0] wr_log[$];
  logic [ADDR_W-1:0] rd_log[$];
  logic [ADDR_W-1:0] exp_q[$];

  assign avm.readdata = rd_q;

  always @(posedge clk) begin
    if (avm.chipselect && !avm.waitrequest) begin
      if (avm.write) begin
        mem[avm.address] <= avm.writedata;
        wr_log.push_back(avm.address);
      end else begin
        rd_q <= (corrupt_en && avm.address == corrupt_addr) ? 32'h0 : mem[avm.address];
        rd_log.push_back(avm.address);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    avm.waitrequest = rand_wait ? ($urandom_range(0, 99) < 30) : 1'b0;
  end

  // ---------------- driver ----------------
  int r_done, r_cs, r_pulses, r_stall_chg, r_be_bad;

  task automatic run_cmd(input logic [1:0] m, input logic [ADDR_W-1:0] b,
                         input logic [ADDR_W:0] n, input logic [31:0] s,
                         input int hold, input int tail);
    logic              prev_stall;
    logic [ADDR_W-1:0] p_addr;
    logic [31:0]       p_wd;
    logic              p_wr;
    @(negedge clk);
    mode = m; base = b; count = n; seed = s; start = 1'b1;
    wr_log.delete(); rd_log.delete();
    @(posedge clk);
    #1 start = (hold > 0);
    r_done = -1; r_cs = 0; r_pulses = 0; r_stall_chg = 0; r_be_bad = 0;
    prev_stall = 1'b0; p_addr = '0; p_wd = '0; p_wr = 1'b0;
    for (int c = 1; c <= 4000; c++) begin
      @(negedge clk);
      if (c >= hold) start = 1'b0;
      if (avm.chipselect) begin
        r_cs++;
        if (avm.byteenable != 4'hF || avm.read != !avm.write) r_be_bad++;
      end
      if (prev_stall && (!avm.chipselect || avm.address != p_addr ||
                         avm.write != p_wr || avm.writedata != p_wd))
        r_stall_chg++;
      prev_stall = avm.chipselect && avm.waitrequest;
      p_addr = avm.address; p_wd = avm.writedata; p_wr = avm.write;
      if (done) begin
        r_pulses++;
        if (r_done < 0) r_done = c;
      end
      if (r_done >= 0 && c >= r_done + tail) break;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL reset_in: busy=%b done=%b want 0 0", busy, done); end
    reset = 1'b0;
    @(negedge clk);
    total++; if (avm.chipselect !== 1'b0) begin bad++; $display("FAIL reset_cs: got %b want 0", avm.chipselect); end
    total++; if (err_count !== '0 || first_err_valid !== 1'b0 || first_err_addr !== '0) begin bad++; $display("FAIL reset_res: err=%0d fev=%b fea=%0d want 0", err_count, first_err_valid, first_err_addr); end
    total++; if (dbg_state !== IDLE) begin bad++; $display("FAIL reset_state: got %0d want %0d", dbg_state, IDLE); end
  endtask

  task automatic test_fill_check();
    run_cmd(2'b10, 11'd0, 12'd16, 32'h1000, 0, 0);
    total++; if (r_done !== 34) begin bad++; $display("FAIL fc_done_cycle: got %0d want 34", r_done); end
    total++; if (r_cs !== 32) begin bad++; $display("FAIL fc_cs_cycles: got %0d want 32", r_cs); end
    total++; if (err_count !== '0 || first_err_valid !== 1'b0) begin bad++; $display("FAIL fc_err: err=%0d fev=%b want 0 0", err_count, first_err_valid); end
    total++; if (r_be_bad !== 0) begin bad++; $display("FAIL fc_qualifiers: got %0d bad cycles want 0", r_be_bad); end
    for (int i = 0; i < 16; i++) begin
      total++; if (mem[i] !== 32'h1000 + 32'(i)) begin bad++; $display("FAIL fc_mem[%0d]: got %h want %h", i, mem[i], 32'h1000 + 32'(i)); end
    end
  endtask

  task automatic test_corrupt();
    corrupt_en = 1'b1; corrupt_addr = 11'd5;
    run_cmd(2'b01, 11'd0, 12'd16, 32'h1000, 0, 0);
    corrupt_en = 1'b0;
    total++; if (r_done !== 18) begin bad++; $display("FAIL cor_done_cycle: got %0d want 18", r_done); end
    total++; if (err_count !== 12'd1) begin bad++; $display("FAIL cor_err_count: got %0d want 1", err_count); end
    total++; if (first_err_valid !== 1'b1 || first_err_addr !== 11'd5) begin bad++; $display("FAIL cor_first: fev=%b addr=%0d want 1 5", first_err_valid, first_err_addr); end
    total++; if (wr_log.size() !== 0 || rd_log.size() !== 16) begin bad++; $display("FAIL cor_xfers: wr=%0d rd=%0d want 0 16", wr_log.size(), rd_log.size()); end
  endtask

  task automatic test_wrap();
    exp_q = '{11'd2046, 11'd2047, 11'd0, 11'd1};
    run_cmd(2'b10, 11'd2046, 12'd4, 32'hABCD_0000, 0, 0);
    total++; if (r_done !== 10) begin bad++; $display("FAIL wrap_done_cycle: got %0d want 10", r_done); end
    total++; if (wr_log.size() !== 4 || rd_log.size() !== 4) begin bad++; $display("FAIL wrap_xfers: wr=%0d rd=%0d want 4 4", wr_log.size(), rd_log.size()); end
    for (int i = 0; i < 4 && i < wr_log.size(); i++) begin
      total++; if (wr_log[i] !== exp_q[i]) begin bad++; $display("FAIL wrap_addr[%0d]: got %0d want %0d", i, wr_log[i], exp_q[i]); end
    end
    total++; if (mem[0] !== 32'hABCD_0002 || mem[2047] !== 32'hABCD_0001) begin bad++; $display("FAIL wrap_mem: m0=%h m2047=%h want abcd0002 abcd0001", mem[0], mem[2047]); end
    total++; if (err_count !== '0) begin bad++; $display("FAIL wrap_err: got %0d want 0", err_count); end
  endtask

  task automatic test_fill_only();
    run_cmd(2'b00, 11'd500, 12'd5, 32'd7, 0, 0);
    total++; if (r_done !== 6) begin bad++; $display("FAIL fo_done_cycle: got %0d want 6", r_done); end
    total++; if (r_cs !== 5 || rd_log.size() !== 0) begin bad++; $display("FAIL fo_xfers: cs=%0d rd=%0d want 5 0", r_cs, rd_log.size()); end
    total++; if (mem[500] !== 32'd7 || mem[504] !== 32'd11) begin bad++; $display("FAIL fo_mem: m500=%0d m504=%0d want 7 11", mem[500], mem[504]); end
  endtask

  task automatic test_random_wait();
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(11'(100 + i));
    rand_wait = 1'b1;
    run_cmd(2'b10, 11'd100, 12'd64, 32'hC0DE_0000, 0, 0);
    rand_wait = 1'b0;
    total++; if (r_done < 129) begin bad++; $display("FAIL rw_done: got %0d want >=129", r_done); end
    total++; if (wr_log.size() !== 64 || rd_log.size() !== 64) begin bad++; $display("FAIL rw_xfers: wr=%0d rd=%0d want 64 64", wr_log.size(), rd_log.size()); end
    for (int i = 0; i < 64 && i < wr_log.size() && i < rd_log.size(); i++) begin
      total++; if (wr_log[i] !== exp_q[i] || rd_log[i] !== exp_q[i]) begin bad++; $display("FAIL rw_addr[%0d]: wr=%0d rd=%0d want %0d", i, wr_log[i], rd_log[i], exp_q[i]); end
    end
    total++; if (r_stall_chg !== 0) begin bad++; $display("FAIL rw_stall_hold: got %0d changes want 0", r_stall_chg); end
    total++; if (err_count !== '0) begin bad++; $display("FAIL rw_err: got %0d want 0", err_count); end
    total++; if (mem[163] !== 32'hC0DE_003F) begin bad++; $display("FAIL rw_mem: got %h want c0de003f", mem[163]); end
  endtask

  task automatic test_count_zero();
    run_cmd(2'b10, 11'd10, 12'd0, 32'h0, 0, 0);
    total++; if (r_done !== 1) begin bad++; $display("FAIL cz_done_cycle: got %0d want 1", r_done); end
    total++; if (r_cs !== 0) begin bad++; $display("FAIL cz_cs: got %0d want 0", r_cs); end
    total++; if (err_count !== '0 || first_err_valid !== 1'b0 || first_err_addr !== '0) begin bad++; $display("FAIL cz_cleared: err=%0d fev=%b fea=%0d want 0", err_count, first_err_valid, first_err_addr); end
  endtask

  task automatic test_start_held();
    run_cmd(2'b00, 11'd700, 12'd20, 32'h55, 10, 15);
    total++; if (r_done !== 21) begin bad++; $display("FAIL sh_done_cycle: got %0d want 21", r_done); end
    total++; if (r_pulses !== 1) begin bad++; $display("FAIL sh_done_pulses: got %0d want 1", r_pulses); end
    total++; if (wr_log.size() !== 20) begin bad++; $display("FAIL sh_writes: got %0d want 20", wr_log.size()); end
  endtask

  task automatic test_reset_drain();
    int pulses;
    @(negedge clk);
    mode = 2'b10; base = 11'd300; count = 12'd8; seed = 32'h5555_0000; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 17; c++) @(negedge clk);
    total++; if (dbg_state !== DRAIN) begin bad++; $display("FAIL rd_in_drain: got %0d want %0d", dbg_state, DRAIN); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++; if (busy !== 1'b0 || done !== 1'b0 || avm.chipselect !== 1'b0) begin bad++; $display("FAIL rd_abort: busy=%b done=%b cs=%b want 0 0 0", busy, done, avm.chipselect); end
    pulses = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL rd_no_done: got %0d pulses want 0", pulses); end
    run_cmd(2'b01, 11'd300, 12'd8, 32'h5555_0000, 0, 0);
    total++; if (r_done !== 10) begin bad++; $display("FAIL rd_rerun_done: got %0d want 10", r_done); end
    total++; if (err_count !== '0 || first_err_valid !== 1'b0) begin bad++; $display("FAIL rd_rerun_err: err=%0d fev=%b want 0 0", err_count, first_err_valid); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_fill_check();
    test_corrupt();
    test_wrap();
    test_fill_only();
    test_random_wait();
    test_count_zero();
    test_start_held();
    test_reset_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
